// File: rtl/divider.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Its start and busy/valid handshake matches the shift-add multiplier, so the two can be swapped.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_i,
  input  logic [WIDTH-1:0] DIN1_i,
  input  logic [WIDTH-1:0] DIN2_i,
  output logic             BUSY_o,
  output logic             VALID_o,
  output logic [WIDTH-1:0] QUOT_o,
  output logic [WIDTH-1:0] REM_o,
  output logic             DIVZ_o
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_valid;
  logic             r_divz;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;

  // The extra trial bit keeps the subtraction exact when the partial remainder's MSB is set.
  assign w_shifted = {r_rem, r_q[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_div};
  assign w_borrow  = (w_shifted < {1'b0, r_div});

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_divz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (EN_i) begin
            if (DIN2_i == '0) begin
              r_q     <= '1;
              r_rem   <= DIN1_i;
              r_divz  <= 1'b1;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_q     <= DIN1_i;
              r_div   <= DIN2_i;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_divz  <= 1'b0;
              r_busy  <= 1'b1;
              r_valid <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY_o  = r_busy;
  assign VALID_o = r_valid;
  assign QUOT_o  = r_q;
  assign REM_o   = r_rem;
  assign DIVZ_o  = r_divz;

endmodule

// File: tb/tb_divider.sv
// Directed and back-to-back random checks for the restoring divider at WIDTH=32.
module tb_divider;

  logic        CLK;
  logic        RST;
  logic        EN_i;
  logic [31:0] DIN1_i;
  logic [31:0] DIN2_i;
  logic        BUSY_o;
  logic        VALID_o;
  logic [31:0] QUOT_o;
  logic [31:0] REM_o;
  logic        DIVZ_o;

  int checks = 0;
  int errors = 0;
  int overlapCnt = 0;

  divider #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .EN_i(EN_i), .DIN1_i(DIN1_i), .DIN2_i(DIN2_i),
    .BUSY_o(BUSY_o), .VALID_o(VALID_o), .QUOT_o(QUOT_o), .REM_o(REM_o), .DIVZ_o(DIVZ_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BUSY_o && VALID_o) overlapCnt++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        divz;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Pulses a start, optionally disturbs EN/DIN mid-run, and waits (bounded) for VALID.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit perturb,
                               output int edges, output int busyCnt);
    EN_i = 1'b1; DIN1_i = a; DIN2_i = b;
    tick();
    EN_i = 1'b0;
    edges = 0;
    busyCnt = 0;
    while (!VALID_o && edges < 40) begin
      if (BUSY_o) busyCnt++;
      if (perturb && edges == 5) begin
        EN_i = 1'b1; DIN1_i = ~a; DIN2_i = b + 32'd3;
      end
      if (perturb && edges == 6) begin
        EN_i = 1'b0; DIN1_i = 32'h0; DIN2_i = 32'h0;
      end
      tick();
      edges++;
    end
  endtask

  task automatic checkResult(input string tag, input vec_t v, input int edges, input int busyCnt);
    checkOutput({tag, "_latency"}, edges, v.divz ? 0 : 32);
    checkOutput({tag, "_busy_cycles"}, busyCnt, v.divz ? 0 : 32);
    checkOutput({tag, "_valid"}, {31'd0, VALID_o}, 32'd1);
    checkOutput({tag, "_quot"}, QUOT_o, v.q);
    checkOutput({tag, "_rem"}, REM_o, v.r);
    checkOutput({tag, "_divz"}, {31'd0, DIVZ_o}, {31'd0, v.divz});
  endtask

  vec_t vecs[12];
  vec_t v;
  int edges;
  int busyCnt;
  logic [31:0] ra;
  logic [31:0] rb;
  int waitCnt;

  initial begin
    vecs[0]  = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          divz: 1'b0};
    vecs[1]  = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,          divz: 1'b0};
    vecs[2]  = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,          divz: 1'b0};
    vecs[3]  = '{a: 32'h80000000,   b: 32'd3,          q: 32'h2AAAAAAA,   r: 32'd2,          divz: 1'b0};
    vecs[4]  = '{a: 32'h00001234,   b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'h00001234,   divz: 1'b1};
    vecs[5]  = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          divz: 1'b0};
    vecs[6]  = '{a: 32'd0,          b: 32'd13,         q: 32'd0,          r: 32'd0,          divz: 1'b0};
    vecs[7]  = '{a: 32'd1000,       b: 32'd1000,       q: 32'd1,          r: 32'd0,          divz: 1'b0};
    vecs[8]  = '{a: 32'hFFFFFFFF,   b: 32'h00000010,   q: 32'h0FFFFFFF,   r: 32'h0000000F,   divz: 1'b0};
    vecs[9]  = '{a: 32'h7FFFFFFF,   b: 32'h80000000,   q: 32'd0,          r: 32'h7FFFFFFF,   divz: 1'b0};
    vecs[10] = '{a: 32'hFFFFFFFE,   b: 32'h80000001,   q: 32'd1,          r: 32'h7FFFFFFD,   divz: 1'b0};
    vecs[11] = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd0,          divz: 1'b1};

    RST = 1'b1; EN_i = 1'b0; DIN1_i = '0; DIN2_i = '0;
    tick();
    tick();
    checkOutput("reset_busy", {31'd0, BUSY_o}, 32'd0);
    checkOutput("reset_valid", {31'd0, VALID_o}, 32'd0);
    checkOutput("reset_quot", QUOT_o, 32'd0);
    checkOutput("reset_rem", REM_o, 32'd0);
    checkOutput("reset_divz", {31'd0, DIVZ_o}, 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 1'b0, edges, busyCnt);
      checkResult($sformatf("vec%0d", i), vecs[i], edges, busyCnt);
      tick();
    end

    // Results stay put in DONE while EN_i is low.
    applyStimulus(32'd100, 32'd7, 1'b0, edges, busyCnt);
    repeat (4) tick();
    checkOutput("hold_valid", {31'd0, VALID_o}, 32'd1);
    checkOutput("hold_quot", QUOT_o, 32'd14);
    checkOutput("hold_rem", REM_o, 32'd2);

    // Mid-run EN_i pulse and operand changes must be ignored.
    applyStimulus(32'd5, 32'd9, 1'b1, edges, busyCnt);
    v = '{a: 32'd5, b: 32'd9, q: 32'd0, r: 32'd5, divz: 1'b0};
    checkResult("perturb", v, edges, busyCnt);
    tick();

    // Reset during RUN aborts the operation.
    EN_i = 1'b1; DIN1_i = 32'd1000; DIN2_i = 32'd3;
    tick();
    EN_i = 1'b0;
    repeat (10) tick();
    checkOutput("midrun_busy_before_rst", {31'd0, BUSY_o}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("midrun_rst_busy", {31'd0, BUSY_o}, 32'd0);
    checkOutput("midrun_rst_valid", {31'd0, VALID_o}, 32'd0);
    checkOutput("midrun_rst_quot", QUOT_o, 32'd0);
    checkOutput("midrun_rst_rem", REM_o, 32'd0);
    checkOutput("midrun_rst_divz", {31'd0, DIVZ_o}, 32'd0);
    repeat (3) tick();
    checkOutput("post_rst_idle_valid", {31'd0, VALID_o}, 32'd0);
    applyStimulus(32'd100, 32'd7, 1'b0, edges, busyCnt);
    v = '{a: 32'd100, b: 32'd7, q: 32'd14, r: 32'd2, divz: 1'b0};
    checkResult("after_rst", v, edges, busyCnt);
    tick();

    // Back-to-back: EN_i held high, new operands presented as each result appears.
    ra = 32'd100; rb = 32'd7;
    EN_i = 1'b1; DIN1_i = ra; DIN2_i = rb;
    tick();
    for (int n = 0; n < 1000; n++) begin
      waitCnt = 0;
      while (!VALID_o && waitCnt < 40) begin
        tick();
        waitCnt++;
      end
      checkOutput("b2b_latency", waitCnt, 32);
      checkOutput("b2b_quot", QUOT_o, ra / rb);
      checkOutput("b2b_rem", REM_o, ra % rb);
      checkOutput("b2b_divz", {31'd0, DIVZ_o}, 32'd0);
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      DIN1_i = ra; DIN2_i = rb;
      if (n == 999) EN_i = 1'b0;
      tick();
      if (n != 999) begin
        checkOutput("b2b_restart_valid", {31'd0, VALID_o}, 32'd0);
        checkOutput("b2b_restart_busy", {31'd0, BUSY_o}, 32'd1);
      end
    end

    checkOutput("busy_valid_exclusive", overlapCnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
